// File: rtl/bigmem_pkg.sv
// Shared constants for the bigmem Unibus memory slave: bus FSM states,
// ARM register indices, the ID word and the byte parity helper.
package bigmem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [31:0] BIGMEM_ID = 32'h424D1002;

  localparam logic [1:0] REG_ID   = 2'd0;
  localparam logic [1:0] REG_PTR  = 2'd1;
  localparam logic [1:0] REG_DATA = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam logic [15:0] DATAVAL_RST = 16'hBAAD;

  // Odd parity: the stored bit makes the 9-bit group hold an odd count of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage

// File: rtl/bigmem_bytearray.sv
// Word-organised storage as separate hi/lo byte arrays with one byte-enabled
// write port and two asynchronous read ports. Parity bits exist only with BIGMEM_PARITY_EN.
module bigmem_bytearray
  import bigmem_pkg::*;
#(
  parameter int AW = 11
) (
  input  logic          CLOCK,
  input  logic [1:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
`ifdef BIGMEM_PARITY_EN
  input  logic          par_inv,
  output logic [1:0]    bus_rpar,
`endif
  input  logic [AW-1:0] arm_raddr,
  output logic [15:0]   arm_rdata,
  input  logic [AW-1:0] bus_raddr,
  output logic [15:0]   bus_rdata
);

  localparam int WORDS = 1 << AW;

  logic [7:0] mem_lo [WORDS];
  logic [7:0] mem_hi [WORDS];

  always_ff @(posedge CLOCK) begin
    if (we[0]) mem_lo[waddr] <= wdata[7:0];
    if (we[1]) mem_hi[waddr] <= wdata[15:8];
  end

  assign arm_rdata = {mem_hi[arm_raddr], mem_lo[arm_raddr]};
  assign bus_rdata = {mem_hi[bus_raddr], mem_lo[bus_raddr]};

`ifdef BIGMEM_PARITY_EN
  logic par_lo [WORDS];
  logic par_hi [WORDS];

  // par_inv lets software plant bad parity to exercise the checker.
  always_ff @(posedge CLOCK) begin
    if (we[0]) par_lo[waddr] <= odd_parity(wdata[7:0]) ^ par_inv;
    if (we[1]) par_hi[waddr] <= odd_parity(wdata[15:8]) ^ par_inv;
  end

  assign bus_rpar = {par_hi[bus_raddr], par_lo[bus_raddr]};
`endif

endmodule

// File: rtl/bigmem.sv
// Parametrised Unibus memory slave (4KB..128KB window) with an ARM register
// window for pointer/data access. Optional byte parity via BIGMEM_PARITY_EN.
module bigmem
  import bigmem_pkg::*;
#(
  parameter logic [17:0] ADDR      = 18'o000000,
  parameter int          LOG2BYTES = 12,
  parameter int          SSYNDLY   = 0
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic [17:0] a_in_h,
  input  logic [1:0]  c_in_h,
  input  logic [15:0] d_in_h,
  input  logic        init_in_h,
  input  logic        msyn_in_h,
  output logic [15:0] d_out_h,
  output logic        ssyn_out_h,
  output logic [1:0]  bus_state
);

  // Bus handshake: MSYN high with a decode hit opens a cycle; SSYN rises once
  // the access is done and stays high until MSYN is seen low.

  localparam int          AW      = LOG2BYTES - 1;
  localparam logic [17:0] HI_MASK = ~((18'd1 << LOG2BYTES) - 18'd1);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [AW-1:0] addrptr;
  logic          autoinc;
  logic [15:0]   dataval;
  logic          reload;
  logic          enable;
  logic          perr;
  logic          injerr;

  logic          arm_act;
  logic          hit;
  logic          access;
  logic [AW-1:0] bus_idx;
  logic [1:0]    bus_we;
  logic [1:0]    mem_we;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;
  logic [AW-1:0] arm_raddr_mem;
  logic [15:0]   arm_rdata_mem;
  logic [15:0]   bus_rdata_mem;
  logic [15:0]   dv_next;
  logic [17:0]   ptr_bytes;
  logic          unused_wdata;

  assign unused_wdata = ^armwdata;
  assign bus_state    = state;

  assign arm_act = armwrite & ~RESET & ~init_in_h;
  assign hit     = enable & ((a_in_h & HI_MASK) == (ADDR & HI_MASK));
  assign bus_idx = a_in_h[AW:1];

  // Any ARM write stalls the bus FSM, so the two never share the write port.
  assign access = ~armwrite & ~RESET & ~init_in_h & msyn_in_h &
                  (state == ST_WAIT) & (cnt == 4'd0);

  always_comb begin
    bus_we = 2'b11;
    if (c_in_h[0]) bus_we = a_in_h[0] ? 2'b10 : 2'b01;
  end

  always_comb begin
    mem_we    = 2'b00;
    mem_waddr = bus_idx;
    mem_wdata = d_in_h;
    if (arm_act && armwaddr == REG_DATA) begin
      mem_we    = 2'b11;
      mem_waddr = addrptr;
      mem_wdata = armwdata[15:0];
    end else if (access && c_in_h[1]) begin
      mem_we = bus_we;
    end
  end

  // A pointer load reads the new location in the same cycle.
  assign arm_raddr_mem = (arm_act && armwaddr == REG_PTR) ? armwdata[AW:1] : addrptr;

`ifdef BIGMEM_PARITY_EN
  logic [1:0] bus_rpar;
  logic       par_err;

  assign par_err = access & ~c_in_h[1] &
                   (~(^{bus_rdata_mem[7:0], bus_rpar[0]}) |
                    ~(^{bus_rdata_mem[15:8], bus_rpar[1]}));
`endif

  bigmem_bytearray #(.AW(AW)) u_array (
    .CLOCK     (CLOCK),
    .we        (mem_we),
    .waddr     (mem_waddr),
    .wdata     (mem_wdata),
`ifdef BIGMEM_PARITY_EN
    .par_inv   (injerr),
    .bus_rpar  (bus_rpar),
`endif
    .arm_raddr (arm_raddr_mem),
    .arm_rdata (arm_rdata_mem),
    .bus_raddr (bus_idx),
    .bus_rdata (bus_rdata_mem)
  );

  // dataval follows the pointed-to word: pending autoinc reload, then bus byte merge.
  always_comb begin
    dv_next = reload ? arm_rdata_mem : dataval;
    if (access && c_in_h[1] && bus_idx == addrptr) begin
      if (bus_we[0]) dv_next[7:0]  = d_in_h[7:0];
      if (bus_we[1]) dv_next[15:8] = d_in_h[15:8];
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET || init_in_h) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      ssyn_out_h <= 1'b0;
      d_out_h    <= 16'h0000;
      addrptr    <= '0;
      autoinc    <= 1'b0;
      dataval    <= DATAVAL_RST;
      reload     <= 1'b0;
    end else begin
      reload  <= 1'b0;
      dataval <= dv_next;
      if (armwrite) begin
        case (armwaddr)
          REG_PTR: begin
            autoinc <= armwdata[31];
            addrptr <= armwdata[AW:1];
            dataval <= arm_rdata_mem;
          end
          REG_DATA: begin
            dataval <= armwdata[15:0];
            if (autoinc) begin
              addrptr <= addrptr + 1'b1;
              reload  <= 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        case (state)
          ST_IDLE: begin
            if (msyn_in_h && hit) begin
              state <= ST_WAIT;
              cnt   <= 4'(SSYNDLY);
            end
          end
          ST_WAIT: begin
            if (!msyn_in_h) begin
              state <= ST_IDLE;
            end else if (cnt == 4'd0) begin
              state      <= ST_RESP;
              ssyn_out_h <= 1'b1;
              d_out_h    <= c_in_h[1] ? 16'h0000 : bus_rdata_mem;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          ST_RESP: begin
            if (!msyn_in_h) begin
              state      <= ST_IDLE;
              ssyn_out_h <= 1'b0;
              d_out_h    <= 16'h0000;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) enable <= 1'b0;
    else if (arm_act && armwaddr == REG_CTRL) enable <= armwdata[31];
  end

`ifdef BIGMEM_PARITY_EN
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      perr   <= 1'b0;
      injerr <= 1'b0;
    end else begin
      if (arm_act && armwaddr == REG_CTRL) begin
        injerr <= armwdata[29];
        if (armwdata[30]) perr <= 1'b0;
      end else if (par_err) begin
        perr <= 1'b1;
      end
    end
  end
`else
  assign perr   = 1'b0;
  assign injerr = 1'b0;
`endif

  always_comb begin
    ptr_bytes = 18'(addrptr) << 1;
    case (armraddr)
      REG_ID:   armrdata = BIGMEM_ID;
      REG_PTR:  armrdata = {autoinc, 13'b0, ptr_bytes};
      REG_DATA: armrdata = {16'h0000, dataval};
      default:  armrdata = {enable, perr, injerr, 11'b0, ADDR};
    endcase
  end

endmodule

// File: tb/tb_bigmem.sv
// Self-checking bench for bigmem: directed scenarios plus randomized bus/ARM
// traffic against an array-based memory model.
module tb_bigmem;

  localparam logic [17:0] ADDR_P  = 18'o040000;
  localparam int          L2B     = 12;
  localparam int          DLY     = 4;
  localparam int          WORDS   = 1 << (L2B - 1);

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        armwrite = 1'b0;
  logic [1:0]  armraddr = 2'd0;
  logic [1:0]  armwaddr = 2'd0;
  logic [31:0] armwdata = 32'h0;
  logic [31:0] armrdata;
  logic [17:0] a_in_h = 18'h0;
  logic [1:0]  c_in_h = 2'b00;
  logic [15:0] d_in_h = 16'h0;
  logic        init_in_h = 1'b0;
  logic        msyn_in_h = 1'b0;
  logic [15:0] d_out_h;
  logic        ssyn_out_h;
  logic [1:0]  bus_state;

  bigmem #(.ADDR(ADDR_P), .LOG2BYTES(L2B), .SSYNDLY(DLY)) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .armwrite   (armwrite),
    .armraddr   (armraddr),
    .armwaddr   (armwaddr),
    .armwdata   (armwdata),
    .armrdata   (armrdata),
    .a_in_h     (a_in_h),
    .c_in_h     (c_in_h),
    .d_in_h     (d_in_h),
    .init_in_h  (init_in_h),
    .msyn_in_h  (msyn_in_h),
    .d_out_h    (d_out_h),
    .ssyn_out_h (ssyn_out_h),
    .bus_state  (bus_state)
  );

  // ---------------- clock / reset
  always #5 CLOCK = ~CLOCK;

  // ---------------- reference model
  logic [15:0] mem_m [WORDS];
  logic        badpar_m [WORDS];
  int          ptr_m;
  logic        autoinc_m;
  logic        dv_baad;
  logic        enable_m;
  logic        perr_m;
  logic        injerr_m;
  logic [15:0] exp_q [$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_reg(input int r);
    logic [17:0] pb;
    pb = 18'(ptr_m * 2);
    case (r)
      1:       return {autoinc_m, 13'b0, pb};
      2:       return {16'h0, (dv_baad ? 16'hBAAD : mem_m[ptr_m])};
      default: return {enable_m, perr_m, injerr_m, 11'b0, ADDR_P};
    endcase
  endfunction

  // ---------------- driver tasks
  task automatic arm_wr(input logic [1:0] r, input logic [31:0] d);
    @(negedge CLOCK);
    armwrite = 1'b1;
    armwaddr = r;
    armwdata = d;
    @(negedge CLOCK);
    armwrite = 1'b0;
    case (r)
      2'd1: begin autoinc_m = d[31]; ptr_m = int'((d >> 1) % WORDS); dv_baad = 1'b0; end
      2'd2: begin
        mem_m[ptr_m] = d[15:0];
        badpar_m[ptr_m] = injerr_m;
        dv_baad = 1'b0;
        if (autoinc_m) ptr_m = (ptr_m + 1) % WORDS;
      end
      2'd3: begin
        enable_m = d[31];
`ifdef BIGMEM_PARITY_EN
        injerr_m = d[29];
        if (d[30]) perr_m = 1'b0;
`endif
      end
      default: ;
    endcase
  endtask

  task automatic arm_rd(input logic [1:0] r, output logic [31:0] d);
    @(negedge CLOCK);
    armraddr = r;
    #1 d = armrdata;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] v;
    for (int r = 1; r <= 3; r++) begin
      arm_rd(2'(r), v);
      check($sformatf("%s_reg%0d", tag, r), v, exp_reg(r));
    end
  endtask

  // One complete bus cycle; coll puts a reg2 ARM write on the decode edge.
  task automatic bus_cycle(input int w, input logic [1:0] c, input logic [15:0] d,
                           input bit oddb, input bit coll, input logic [15:0] cd,
                           input string tag);
    int lat;
    int exp_lat;
    logic [15:0] e;
    lat = 0;
    exp_lat = DLY + 2 + (coll ? 1 : 0);
    if (!c[1]) exp_q.push_back(mem_m[w]);
    @(negedge CLOCK);
    a_in_h = ADDR_P + 18'(w * 2) + (oddb ? 18'd1 : 18'd0);
    c_in_h = c;
    d_in_h = d;
    msyn_in_h = 1'b1;
    if (coll) begin
      armwrite = 1'b1;
      armwaddr = 2'd2;
      armwdata = {16'h0, cd};
    end
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge CLOCK);
      #1;
      if (coll && k == 1) armwrite = 1'b0;
      if (ssyn_out_h) lat = k;
    end
    check({tag, "_lat"}, lat, exp_lat);
    if (coll) begin
      mem_m[ptr_m] = cd;
      badpar_m[ptr_m] = injerr_m;
      dv_baad = 1'b0;
      if (autoinc_m) ptr_m = (ptr_m + 1) % WORDS;
    end
    if (!c[1]) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, {16'h0, d_out_h}, {16'h0, e});
      if (badpar_m[w]) perr_m = 1'b1;
    end else if (!c[0]) begin
      mem_m[w] = d;
      badpar_m[w] = injerr_m;
    end else begin
      if (oddb) mem_m[w][15:8] = d[15:8];
      else      mem_m[w][7:0]  = d[7:0];
      if (injerr_m) badpar_m[w] = 1'b1;
    end
    @(negedge CLOCK);
    msyn_in_h = 1'b0;
    @(posedge CLOCK);
    #1;
    check({tag, "_release"}, {15'h0, ssyn_out_h, d_out_h}, 32'h0);
    @(negedge CLOCK);
  endtask

  task automatic no_resp(input logic [17:0] a, input int cycles, input string tag);
    int seen;
    seen = 0;
    @(negedge CLOCK);
    a_in_h = a;
    c_in_h = 2'b00;
    msyn_in_h = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      @(posedge CLOCK);
      #1 if (ssyn_out_h) seen++;
    end
    check(tag, seen, 0);
    @(negedge CLOCK);
    msyn_in_h = 1'b0;
    @(negedge CLOCK);
  endtask

  // ---------------- main sequence
  initial begin
    logic [31:0] v;
    int seen;
    int w;
    int op;

    ptr_m = 0; autoinc_m = 1'b0; dv_baad = 1'b1;
    enable_m = 1'b0; perr_m = 1'b0; injerr_m = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      mem_m[i] = 16'h0;
      badpar_m[i] = 1'b0;
    end

    repeat (3) @(negedge CLOCK);
    RESET = 1'b0;
    #1;
    check("rst_ssyn", {31'h0, ssyn_out_h}, 32'h0);
    check("rst_dout", {16'h0, d_out_h}, 32'h0);
    check("rst_state", {30'h0, bus_state}, 32'h0);
    arm_rd(2'd0, v);
    check("id", v, 32'h424D1002);
    check_regs("rst");

    // Fill the whole window so every later read is modelled.
    arm_wr(2'd1, 32'h80000000);
    for (int i = 0; i < WORDS; i++) arm_wr(2'd2, {16'h0, 16'($urandom)});
    check_regs("fill");

    // Enable gating.
    arm_wr(2'd3, 32'h0);
    no_resp(ADDR_P, 20, "disabled_nossyn");
    arm_wr(2'd3, 32'h80000000);
    bus_cycle(0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0, "en_dati");

    // Auto-increment block fill.
    arm_wr(2'd1, 32'h80000000);
    arm_wr(2'd2, 32'd1);
    arm_wr(2'd2, 32'd2);
    arm_wr(2'd2, 32'd3);
    arm_rd(2'd1, v);
    check("fill3_ptr", v, 32'h80000006);
    check_regs("fill3");
    bus_cycle(1, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0, "fill3_dati");

    // DATOB hi byte, dataval follows without a reload.
    arm_wr(2'd1, 32'd4);
    bus_cycle(2, 2'b10, 16'h1234, 1'b0, 1'b0, 16'h0, "datob_pre");
    bus_cycle(2, 2'b11, 16'hAB00, 1'b1, 1'b0, 16'h0, "datob");
    arm_rd(2'd2, v);
    check("datob_dataval", v, 32'h0000AB34);
    bus_cycle(2, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0, "datob_dati");

    // MSYN abort while the counter is at 2.
    seen = 0;
    @(negedge CLOCK);
    a_in_h = ADDR_P + 18'd20;
    c_in_h = 2'b10;
    d_in_h = ~mem_m[10];
    msyn_in_h = 1'b1;
    for (int k = 0; k < DLY - 1; k++) begin
      @(posedge CLOCK);
      #1 if (ssyn_out_h) seen++;
    end
    @(negedge CLOCK);
    msyn_in_h = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLOCK);
      #1 if (ssyn_out_h) seen++;
    end
    check("abort_nossyn", seen, 0);
    bus_cycle(10, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0, "abort_dati");

    // ARM write on the decode edge.
    arm_wr(2'd1, 32'd40);
    bus_cycle(30, 2'b10, 16'hC3E1, 1'b0, 1'b1, 16'h5A5A, "coll");
    bus_cycle(30, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0, "coll_dati");
    check_regs("coll");

    // INIT overrides a simultaneous ARM write and keeps enable.
    arm_wr(2'd1, 32'h80000010);
    @(negedge CLOCK);
    init_in_h = 1'b1;
    armwrite = 1'b1;
    armwaddr = 2'd3;
    armwdata = 32'h0;
    @(negedge CLOCK);
    init_in_h = 1'b0;
    armwrite = 1'b0;
    ptr_m = 0; autoinc_m = 1'b0; dv_baad = 1'b1;
    check_regs("init");

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 5);
      w = $urandom_range(0, WORDS - 1);
      case (op)
        0: bus_cycle(w, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0, $sformatf("rnd%0d_dati", it));
        1: bus_cycle(w, 2'b10, 16'($urandom), 1'b0, 1'b0, 16'h0, $sformatf("rnd%0d_dato", it));
        2: bus_cycle(w, 2'b11, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 16'h0,
                     $sformatf("rnd%0d_datob", it));
        3: begin
          arm_wr(2'd1, {1'($urandom_range(0, 1)), 19'h0, 12'(w * 2)});
          check_regs($sformatf("rnd%0d_ptr", it));
        end
        4: begin
          arm_wr(2'd2, $urandom);
          check_regs($sformatf("rnd%0d_data", it));
        end
        default: no_resp(ADDR_P + 18'd4096 + 18'(w * 2), 8, $sformatf("rnd%0d_miss", it));
      endcase
      repeat ($urandom_range(0, 2)) @(negedge CLOCK);
    end
    check_regs("rnd_end");

`ifdef BIGMEM_PARITY_EN
    arm_wr(2'd3, 32'hA0000000);
    bus_cycle(5, 2'b10, 16'h0F0F, 1'b0, 1'b0, 16'h0, "par_dato");
    bus_cycle(5, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0, "par_dati");
    arm_rd(2'd3, v);
    check("par_perr_set", {31'h0, v[30]}, 32'h1);
    arm_wr(2'd3, 32'hC0000000);
    arm_rd(2'd3, v);
    check("par_perr_clr", {31'h0, v[30]}, 32'h0);
    bus_cycle(5, 2'b10, 16'h0F0F, 1'b0, 1'b0, 16'h0, "par_fix");
    bus_cycle(5, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0, "par_clean");
    check_regs("par_end");
`else
    arm_wr(2'd3, 32'hE0000000);
    arm_rd(2'd3, v);
    check("nopar_reg3", v, {3'b100, 11'b0, ADDR_P});
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bigmem.md
# bigmem

Parametrised Unibus memory slave with an ARM-side register window, the sized successor to the fixed 4KB memory. It answers DATI/DATIP/DATO/DATOB cycles in a programmable window of 4KB–128KB with a programmable MSYN→SSYN delay. The ARM window supports auto-incrementing pointer loads for fast block fill. It sits on the Zynq fabric bus beside the other Unibus slaves.

## Interface
- ADDR, 18'o000000: base byte address; must be aligned to the window size
- LOG2BYTES, 12: window size is 2**LOG2BYTES bytes; legal range 12..17
- SSYNDLY, 0: extra CLOCK cycles between address decode and SSYN assertion; legal range 0..15
- CLOCK  in  1  fabric clock, all logic on rising edge
- RESET  in  1  synchronous, active-high; clears everything including enable
- armwrite  in  1  ARM register write strobe, one cycle
- armraddr  in  2  ARM read register select
- armwaddr  in  2  ARM write register select
- armwdata  in  32  ARM write data
- armrdata  out  32  ARM read data, combinational from armraddr
- a_in_h  in  18  Unibus address
- c_in_h  in  2  Unibus control: [1]=write, [0]=byte (with [1])
- d_in_h  in  16  Unibus write data
- init_in_h  in  1  Unibus INIT
- msyn_in_h  in  1  Unibus MSYN
- d_out_h  out  16  read data to bus; 0 when not responding
- ssyn_out_h  out  1  Unibus SSYN

## Operation
- ARM registers (read):
  - 0: 32'h424D1002 ('BM', nreg code 1, version 002).
  - 1: {autoinc, 13'b0, addrptr[LOG2BYTES-1:1], 1'b0}, zero-extended.
  - 2: {16'b0, dataval}.
  - 3: {enable, perr, injerr, 11'b0, ADDR}.
- ARM writes:
  - 1: autoinc<=wdata[31]; addrptr<=wdata[LOG2BYTES-1:1]; dataval<=mem[new ptr].
  - 2: mem[addrptr]<=wdata[15:0]; dataval<=wdata[15:0]; if autoinc, addrptr+1 (wraps within window) and dataval reloads from the new location the following cycle.
  - 3: enable<=wdata[31]; wdata[30]=1 clears perr; injerr<=wdata[29].
- Decode hit: enable & a_in_h[17:LOG2BYTES]==ADDR[17:LOG2BYTES]. Word index a_in_h[LOG2BYTES-1:1].
- Bus FSM:
  - IDLE: on msyn & hit, go to WAIT with cnt=SSYNDLY.
  - WAIT: cnt decrements each cycle. At cnt==0, perform the access and go to RESP. If msyn drops, go to IDLE with no access.
  - RESP: ssyn=1 and d_out_h holds. When msyn drops, go to IDLE and clear ssyn and d_out_h.
- Access rules:
  - c[1]=0 (read): d_out_h<=mem word.
  - c=2'b10: write the full word.
  - c=2'b11: write the hi byte if a[0]=1, else the lo byte.
  - A bus write to the word at addrptr updates the matching dataval bytes in the same edge.
- Simultaneous events: armwrite has priority. The bus FSM holds state and counter for that cycle; nothing is lost, and SSYN is delayed by one cycle.
- init_in_h: FSM to IDLE, ssyn/d_out_h=0, addrptr=0, autoinc=0, dataval=16'hBAAD. Enable, perr, injerr and memory are kept. init overrides armwrite.
- RESET: same as init_in_h, plus enable=0, perr=0, injerr=0. Memory contents are not cleared.

## Timing
- Reset values: d_out_h=0, ssyn_out_h=0, armrdata reflects cleared registers.
- SSYNDLY=0: msyn&hit sampled at edge N → WAIT. Access and ssyn=1 at edge N+1.
- SSYNDLY=D: ssyn at edge N+1+D.
- msyn low sampled at edge M → ssyn/d_out_h=0 after edge M.
- RESP never re-triggers. A new cycle requires passing through IDLE with msyn low for at least one cycle.
- ARM pointer load: dataval is valid the cycle after the armwrite edge.
- Autoinc write: dataval is valid two cycles after the armwrite edge.

## Configuration
- BIGMEM_PARITY_EN defined:
  - Stores one odd-parity bit per byte, computed on every ARM and bus write.
  - If injerr=1, stored parity is inverted on writes.
  - A bus read with mismatched parity sets sticky perr. Data is still returned and SSYN still asserts.
- BIGMEM_PARITY_EN undefined:
  - No parity storage.
  - perr and injerr read 0; writes to their bits are ignored.

## Structure
- Package bigmem_pkg holds:
  - FSM state enum (IDLE, WAIT, RESP).
  - ID constant 32'h424D1002.
  - Register index constants 0..3.
  - Parity helper function.
- Sub-module bigmem_bytearray:
  - 2**(LOG2BYTES-1) words as hi/lo byte arrays (plus parity bits under the macro).
  - One write port with 2-bit byte enable.
  - Two asynchronous read ports (ARM, bus).

## Test plan
- ARM fill: write reg1=32'h80000000, then reg2 = 1,2,3. Expect reg1 reads 6 and bus DATI at ADDR+2 returns 2.
- Enable gating: reg3=0, then DATI at ADDR. Expect no SSYN after 20 cycles. Set enable; the retry gets SSYN at N+1+SSYNDLY.
- DATOB: c=2'b11 to ADDR+5 with d=16'hAB00, on a word holding 16'h1234. Expect the word reads 16'hAB34. With reg1 pointing at ADDR+4, dataval reads 16'hAB34 without an ARM reload.
- MSYN abort: SSYNDLY=4, drop msyn at cnt==2 during a DATO. Expect memory unchanged and ssyn never high.
- Collision: armwrite on the same edge as the decode cycle. Expect SSYN one cycle later than nominal and both writes landed.
- Parity (macro on): set injerr, write a word, DATI it. Expect perr=1. Write reg3 bit30=1; expect perr=0.
